// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator/checker: one message bit per accepted clock, MSB first.
// Produces the final CRC (with output XOR) and a zero-residue flag once per frame.
module crc_serial_engine #(
    parameter int                 CRC_W   = 16,
    parameter logic [CRC_W-1:0]   POLY    = 16'h8005,
    parameter logic [CRC_W-1:0]   INIT    = 16'h0000,
    parameter logic [CRC_W-1:0]   XOR_OUT = 16'h0000,
    parameter int                 N_BITS  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             data,
    input  logic             data_valid,
    output logic             busy,
    output logic             done,
    output logic [CRC_W-1:0] r,
    output logic             crc_ok
);

    localparam int CNT_W = $clog2(N_BITS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CRC_W-1:0] crc_q,   crc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CRC_W-1:0] r_q,     r_d;
    logic             ok_q,    ok_d;

    logic [CRC_W-1:0] crc_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_bit;

    // One LFSR step: the feedback bit is the outgoing MSB combined with the message bit.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic             bit_in);
        logic fb;
        fb = crc[CRC_W-1] ^ bit_in;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
    endfunction

    assign crc_next = crc_step(crc_q, data);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign last_bit = (cnt_inc == CNT_W'(N_BITS));

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        ok_d    = ok_q;
        if (start) begin
            // A start always wins, even over a bit presented in the same cycle.
            state_d = S_SHIFT;
            crc_d   = INIT;
            cnt_d   = '0;
            r_d     = '0;
            ok_d    = 1'b0;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (data_valid) begin
                        crc_d = crc_next;
                        cnt_d = cnt_inc;
                        if (last_bit) begin
                            state_d = S_DONE;
                            r_d     = crc_next ^ XOR_OUT;
                            ok_d    = (crc_next == '0);
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_IDLE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            crc_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            ok_q    <= ok_d;
        end
    end

    // DONE lasts exactly one cycle, so the pulse is decoded straight from the state.
    assign busy   = (state_q == S_SHIFT);
    assign done   = (state_q == S_DONE);
    assign r      = r_q;
    assign crc_ok = ok_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Scoreboard bench for crc_serial_engine: four builds (N_BITS 32, 2, 72, 88) share clock and reset.
// Drivers queue expected results; a monitor pops and compares on every done pulse.
module tb_crc_serial_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st  [4];
    logic        dd  [4];
    logic        dv  [4];
    logic        busy_w [4];
    logic        done_w [4];
    logic [15:0] r_w    [4];
    logic        ok_w   [4];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          idx;
        logic [15:0] r;
        logic        ok;
        logic        chk_r;
        int          cyc;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_serial_engine #(.N_BITS(32)) u32 (
        .clock(clk), .reset(rst), .start(st[0]), .data(dd[0]), .data_valid(dv[0]),
        .busy(busy_w[0]), .done(done_w[0]), .r(r_w[0]), .crc_ok(ok_w[0]));
    crc_serial_engine #(.N_BITS(2)) u2 (
        .clock(clk), .reset(rst), .start(st[1]), .data(dd[1]), .data_valid(dv[1]),
        .busy(busy_w[1]), .done(done_w[1]), .r(r_w[1]), .crc_ok(ok_w[1]));
    crc_serial_engine #(.N_BITS(72)) u72 (
        .clock(clk), .reset(rst), .start(st[2]), .data(dd[2]), .data_valid(dv[2]),
        .busy(busy_w[2]), .done(done_w[2]), .r(r_w[2]), .crc_ok(ok_w[2]));
    crc_serial_engine #(.N_BITS(88)) u88 (
        .clock(clk), .reset(rst), .start(st[3]), .data(dd[3]), .data_valid(dv[3]),
        .busy(busy_w[3]), .done(done_w[3]), .r(r_w[3]), .crc_ok(ok_w[3]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_w[i] === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: inst %0d got done=1 expected no done", i);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("done_inst", i, e.idx);
                    check("done_latency_cycle", cyc, e.cyc);
                    if (e.chk_r) check("r", {16'h0, r_w[i]}, {16'h0, e.r});
                    check("crc_ok", {31'h0, ok_w[i]}, {31'h0, e.ok});
                    check("busy_at_done", {31'h0, busy_w[i]}, 32'h0);
                end
            end
        end
    end

    // Feed n bits MSB first; push the expectation alongside the last accepted bit.
    task automatic feed(input int idx, input logic [127:0] msg, input int n, input int stall_pct,
                        input logic push, input logic [15:0] er, input logic eok, input logic chk_r);
        int k;
        k = n - 1;
        while (k >= 0) begin
            check("busy_in_shift", {31'h0, busy_w[idx]}, 32'h1);
            if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                dv[idx] = 1'b0;
                dd[idx] = $urandom_range(1);
            end else begin
                dv[idx] = 1'b1;
                dd[idx] = msg[k];
                if (k == 0 && push) sbq.push_back('{idx, er, eok, chk_r, cyc + 1});
                k--;
            end
            @(negedge clk);
        end
        dv[idx] = 1'b0;
        dd[idx] = 1'b0;
    endtask

    task automatic pulse_start(input int idx);
        @(negedge clk);
        st[idx] = 1'b1;
        @(negedge clk);
        st[idx] = 1'b0;
    endtask

    task automatic run_frame(input int idx, input logic [127:0] msg, input int n,
                             input int stall_pct, input logic [15:0] er, input logic eok,
                             input logic chk_r);
        pulse_start(idx);
        feed(idx, msg, n, stall_pct, 1'b1, er, eok, chk_r);
        repeat (3) @(negedge clk);
        if (chk_r) check("r_held_idle", {16'h0, r_w[idx]}, {16'h0, er});
        check("crc_ok_held_idle", {31'h0, ok_w[idx]}, {31'h0, eok});
        check("busy_idle", {31'h0, busy_w[idx]}, 32'h0);
    endtask

    localparam logic [127:0] MSG_123 = 128'h313233343536373839;
    localparam logic [127:0] MSG_CHK = 128'h313233343536373839FEE8;

    initial begin
        for (int i = 0; i < 4; i++) begin
            st[i] = 1'b0;
            dd[i] = 1'b0;
            dv[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("reset_busy",  {31'h0, busy_w[i]}, 32'h0);
            check("reset_done",  {31'h0, done_w[i]}, 32'h0);
            check("reset_r",     {16'h0, r_w[i]},    32'h0);
            check("reset_crcok", {31'h0, ok_w[i]},   32'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        // All-zero frame: zero CRC, zero residue.
        run_frame(0, 128'h0, 32, 0, 16'h0000, 1'b1, 1'b1);
        // Two-bit frame 1,0: 0x8005 after the first bit, then 0x800F.
        run_frame(1, 128'h2, 2, 0, 16'h800F, 1'b0, 1'b1);
        // "123456789" check value for CRC-16/UMTS.
        run_frame(2, MSG_123, 72, 0, 16'hFEE8, 1'b0, 1'b1);
        // Message with its CRC appended leaves a zero residue; a flipped bit does not.
        run_frame(3, MSG_CHK, 88, 0, 16'h0000, 1'b1, 1'b1);
        run_frame(3, MSG_CHK ^ (128'd1 << 50), 88, 0, 16'h0000, 1'b0, 1'b0);
        // Same message with random stalls on data_valid.
        run_frame(2, MSG_123, 72, 30, 16'hFEE8, 1'b0, 1'b1);

        // Reset mid-frame: no done, everything back to zero.
        pulse_start(2);
        feed(2, MSG_123 >> 62, 10, 0, 1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_busy",  {31'h0, busy_w[2]}, 32'h0);
        check("midreset_done",  {31'h0, done_w[2]}, 32'h0);
        check("midreset_r",     {16'h0, r_w[2]},    32'h0);
        check("midreset_crcok", {31'h0, ok_w[2]},   32'h0);
        // Restart over a partial frame: count restarts from zero.
        pulse_start(2);
        feed(2, 128'hFFFFF, 20, 0, 1'b0, 16'h0, 1'b0, 1'b0);
        run_frame(2, MSG_123, 72, 0, 16'hFEE8, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_done: got %0d pending expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
